// File: rtl/adc_stream_pkg.sv
// ---------------------------------------------------------------------------
// adc_stream_pkg
// Shared constants for the ADC capture stream unpacker.
//
// Packed word layout (32 bits, sent MSB byte first):
//   [31:30] merge location (index of the trigger sample, 2'b11 = none)
//   [29:20] sample 2
//   [19:10] sample 1
//   [9:0]   sample 0
// ---------------------------------------------------------------------------
package adc_stream_pkg;

  // The packing format fixes the sample width at 10 bits.
  localparam int SAMPLE_W         = 10;
  localparam int WORD_W           = 32;
  localparam int BYTES_PER_WORD   = 4;
  localparam int SAMPLES_PER_WORD = 3;

  // Bit offsets of the fields inside a packed word
  localparam int SAMPLE0_OFS = 0;
  localparam int SAMPLE1_OFS = 10;
  localparam int SAMPLE2_OFS = 20;
  localparam int LOC_OFS     = 30;

  // Merge location value meaning "trigger not in this word"
  localparam logic [1:0] LOC_NONE = 2'b11;

  // Unpacker FSM encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_COLLECT = 2'd0;
  localparam state_t ST_EMIT    = 2'd1;
  localparam state_t ST_DONE    = 2'd2;

endpackage

// File: rtl/adc_word_assembler.sv
// ---------------------------------------------------------------------------
// adc_word_assembler
// Collects four stream bytes (first byte = most significant) into one
// 32-bit packed word.
//
// Ports:
//   clk            sole clock
//   reset_i        asynchronous active-high reset
//   clear_i        synchronous restart, drops any partial word
//   byte_i         stream byte
//   byte_accept_i  byte_i is consumed this cycle
//   word_valid_o   combinational pulse: the 4th byte is consumed this cycle
//   word_o         last completed word, held until the next one completes
// ---------------------------------------------------------------------------
module adc_word_assembler (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_accept_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  import adc_stream_pkg::*;

  logic [23:0]       shift_q;
  logic [1:0]        byte_cnt_q;
  logic [WORD_W-1:0] word_q;
  logic              last_byte;

  // The word is complete when the final byte of the group is consumed
  always_comb begin
    last_byte = byte_accept_i && (byte_cnt_q == 2'(BYTES_PER_WORD - 1));
  end

  // The first three bytes build up in shift_q; the fourth byte is combined
  // with them directly into word_q so the word is ready one edge after the
  // last byte. byte_cnt_q wraps 3 -> 0 naturally.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      shift_q    <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
    end else if (clear_i) begin
      shift_q    <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
    end else if (byte_accept_i) begin
      shift_q    <= {shift_q[15:0], byte_i};
      byte_cnt_q <= byte_cnt_q + 2'd1;
      if (last_byte) begin
        word_q <= {shift_q, byte_i};
      end
    end
  end

  assign word_valid_o = last_byte;
  assign word_o       = word_q;

endmodule

// File: rtl/adc_stream_unpack.sv
// ---------------------------------------------------------------------------
// adc_stream_unpack
// Consumer end of the ADC capture byte stream: rebuilds packed words and
// emits the three 10-bit samples of each word in capture order, flagging the
// trigger sample and counting samples.
//
// Ports:
//   clk              sole clock
//   reset_i          asynchronous active-high reset
//   clear_i          synchronous restart (wins over every other event)
//   max_samples_i    sample limit, 0 = unlimited
//   byte_i/byte_valid_i/byte_ready_o          input byte stream
//   sample_o/sample_valid_o/sample_ready_i    output sample stream
//   sample_trig_o    current sample_o is the trigger sample
//   trig_seen_o      sticky, trigger sample has been emitted
//   pretrig_count_o  samples emitted before the trigger sample
//   sample_count_o   samples emitted since reset/clear (saturating)
//   done_o           sticky, sample limit reached
// SAMPLE_W must stay 10; the packed word layout depends on it.
// ---------------------------------------------------------------------------
module adc_stream_unpack #(
  parameter int SAMPLE_W = 10,
  parameter int COUNT_W  = 32
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic                clear_i,
  input  logic [COUNT_W-1:0]  max_samples_i,
  input  logic [7:0]          byte_i,
  input  logic                byte_valid_i,
  output logic                byte_ready_o,
  output logic [SAMPLE_W-1:0] sample_o,
  output logic                sample_valid_o,
  input  logic                sample_ready_i,
  output logic                sample_trig_o,
  output logic                trig_seen_o,
  output logic [COUNT_W-1:0]  pretrig_count_o,
  output logic [COUNT_W-1:0]  sample_count_o,
  output logic                done_o
);

  import adc_stream_pkg::*;

  state_t             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] pretrig_q, pretrig_d;
  logic               trig_seen_q, trig_seen_d;
  logic               done_q, done_d;

  logic               byte_accept;
  logic               word_valid;
  logic [31:0]        word;
  logic [1:0]         loc;
  logic               trig_now;
  logic               sample_accept;
  logic [COUNT_W-1:0] count_inc;

  adc_word_assembler u_assembler (
    .clk           (clk),
    .reset_i       (reset_i),
    .clear_i       (clear_i),
    .byte_i        (byte_i),
    .byte_accept_i (byte_accept),
    .word_valid_o  (word_valid),
    .word_o        (word)
  );

  // Handshake qualifiers and the trigger decode. The trigger can only fire
  // once per run: after trig_seen is set, later merge locations are ignored.
  // The sample count saturates at all-ones instead of wrapping.
  always_comb begin
    byte_accept   = byte_valid_i && (state_q == ST_COLLECT);
    loc           = word[LOC_OFS +: 2];
    trig_now      = (state_q == ST_EMIT) && !trig_seen_q &&
                    (loc != LOC_NONE) && (idx_q == loc);
    sample_accept = (state_q == ST_EMIT) && sample_ready_i;
    count_inc     = (count_q == {COUNT_W{1'b1}}) ? count_q : count_q + 1'b1;
  end

  // Next-state logic. Reaching the limit jumps straight to DONE, discarding
  // whatever samples of the current word have not been emitted yet.
  // pretrig follows the count until the trigger sample goes out, at which
  // point it keeps the count from before that sample.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    count_d     = count_q;
    pretrig_d   = pretrig_q;
    trig_seen_d = trig_seen_q;
    done_d      = done_q;

    case (state_q)
      ST_COLLECT: begin
        if (word_valid) begin
          state_d = ST_EMIT;
          idx_d   = 2'd0;
        end
      end
      ST_EMIT: begin
        if (sample_accept) begin
          count_d = count_inc;
          if (trig_now) begin
            trig_seen_d = 1'b1;
            pretrig_d   = count_q;
          end
          if ((max_samples_i != '0) && (count_inc == max_samples_i)) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
            idx_d   = 2'd0;
          end else if (idx_q == 2'(SAMPLES_PER_WORD - 1)) begin
            state_d = ST_COLLECT;
            idx_d   = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_COLLECT;
        idx_d   = 2'd0;
      end
    endcase

    if (!trig_seen_d) begin
      pretrig_d = count_d;
    end
  end

  // State registers; clear_i restarts everything and overrides all
  // same-cycle activity
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_COLLECT;
      idx_q       <= '0;
      count_q     <= '0;
      pretrig_q   <= '0;
      trig_seen_q <= 1'b0;
      done_q      <= 1'b0;
    end else if (clear_i) begin
      state_q     <= ST_COLLECT;
      idx_q       <= '0;
      count_q     <= '0;
      pretrig_q   <= '0;
      trig_seen_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      pretrig_q   <= pretrig_d;
      trig_seen_q <= trig_seen_d;
      done_q      <= done_d;
    end
  end

  // Sample selection from the held word; only registers feed this mux so the
  // output is stable while the consumer stalls
  always_comb begin
    case (idx_q)
      2'd0:    sample_o = word[SAMPLE0_OFS +: SAMPLE_W];
      2'd1:    sample_o = word[SAMPLE1_OFS +: SAMPLE_W];
      2'd2:    sample_o = word[SAMPLE2_OFS +: SAMPLE_W];
      default: sample_o = '0;
    endcase
  end

  assign byte_ready_o    = (state_q == ST_COLLECT);
  assign sample_valid_o  = (state_q == ST_EMIT);
  assign sample_trig_o   = trig_now;
  assign trig_seen_o     = trig_seen_q;
  assign pretrig_count_o = pretrig_q;
  assign sample_count_o  = count_q;
  assign done_o          = done_q;

endmodule

// File: tb/tb_adc_stream_unpack.sv
// ---------------------------------------------------------------------------
// tb_adc_stream_unpack
// Self-checking bench for adc_stream_unpack. A sample-level reference model
// (count, pretrig, trigger-seen, done) is updated each time a sample is
// consumed; expected samples are sliced arithmetically from the word.
// Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_adc_stream_unpack;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        clear_i;
  logic [31:0] max_samples_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic [9:0]  sample_o;
  logic        sample_valid_o;
  logic        sample_ready_i;
  logic        sample_trig_o;
  logic        trig_seen_o;
  logic [31:0] pretrig_count_o;
  logic [31:0] sample_count_o;
  logic        done_o;

  int nVec = 0;
  int nErr = 0;

  // Reference model state
  logic [31:0] mCount;
  logic [31:0] mPre;
  logic [31:0] mMax;
  bit          mTrigSeen;
  bit          mDone;

  adc_stream_unpack #(.SAMPLE_W(10), .COUNT_W(32)) dut (
    .clk             (clk),
    .reset_i         (reset_i),
    .clear_i         (clear_i),
    .max_samples_i   (max_samples_i),
    .byte_i          (byte_i),
    .byte_valid_i    (byte_valid_i),
    .byte_ready_o    (byte_ready_o),
    .sample_o        (sample_o),
    .sample_valid_o  (sample_valid_o),
    .sample_ready_i  (sample_ready_i),
    .sample_trig_o   (sample_trig_o),
    .trig_seen_o     (trig_seen_o),
    .pretrig_count_o (pretrig_count_o),
    .sample_count_o  (sample_count_o),
    .done_o          (done_o)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Safety net so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic model_reset();
    mCount    = '0;
    mPre      = '0;
    mTrigSeen = 1'b0;
    mDone     = 1'b0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    model_reset();
  endtask

  // Offer one word byte by byte, with occasional idle cycles
  task automatic send_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        byte_valid_i = 1'b0;
        @(negedge clk);
      end
      nVec++;
      if (byte_ready_o !== 1'b1) begin
        $display("[TB] FAIL byte_ready byte%0d: got %b want 1", b, byte_ready_o);
        nErr++;
      end
      byte_i       = w[31 - 8*b -: 8];
      byte_valid_i = 1'b1;
      @(negedge clk);
    end
    byte_valid_i = 1'b0;
  endtask

  // Consume the samples of word w with the given ready probability,
  // checking every cycle against the model
  task automatic drain_word(input logic [31:0] w, input int readyPct);
    int          idx;
    int          budget;
    logic [9:0]  expSample;
    logic        expTrig;
    bit          rdy;
    idx    = 0;
    budget = 0;
    while (idx < 3 && !mDone && budget < 300) begin
      expSample = 10'((w >> (10 * idx)) & 32'h3FF);
      expTrig   = !mTrigSeen && (int'(w[31:30]) == idx);
      nVec++;
      if (sample_valid_o !== 1'b1) begin
        $display("[TB] FAIL sample_valid idx%0d: got %b want 1", idx, sample_valid_o);
        nErr++;
      end
      nVec++;
      if (sample_o !== expSample) begin
        $display("[TB] FAIL sample idx%0d: got %h want %h", idx, sample_o, expSample);
        nErr++;
      end
      nVec++;
      if (sample_trig_o !== expTrig) begin
        $display("[TB] FAIL sample_trig idx%0d: got %b want %b", idx, sample_trig_o, expTrig);
        nErr++;
      end
      nVec++;
      if (sample_count_o !== mCount || pretrig_count_o !== mPre || trig_seen_o !== mTrigSeen) begin
        $display("[TB] FAIL counters: got cnt=%0d pre=%0d seen=%b want cnt=%0d pre=%0d seen=%b",
                 sample_count_o, pretrig_count_o, trig_seen_o, mCount, mPre, mTrigSeen);
        nErr++;
      end
      rdy            = ($urandom_range(0, 99) < readyPct);
      sample_ready_i = rdy;
      @(negedge clk);
      if (rdy) begin
        if (expTrig) begin
          mTrigSeen = 1'b1;
          mPre      = mCount;
        end
        if (mCount != 32'hFFFF_FFFF) mCount = mCount + 1;
        if (!mTrigSeen) mPre = mCount;
        if (mMax != 0 && mCount == mMax) mDone = 1'b1;
        idx++;
      end
      budget++;
    end
    sample_ready_i = 1'b0;
    nVec++;
    if (budget >= 300) begin
      $display("[TB] FAIL drain_timeout: got %0d samples want 3", idx);
      nErr++;
    end
    nVec++;
    if (done_o !== mDone || sample_valid_o !== 1'b0 || byte_ready_o !== !mDone) begin
      $display("[TB] FAIL post_word: got done=%b sv=%b br=%b want done=%b sv=0 br=%b",
               done_o, sample_valid_o, byte_ready_o, mDone, !mDone);
      nErr++;
    end
    nVec++;
    if (sample_count_o !== mCount || pretrig_count_o !== mPre || trig_seen_o !== mTrigSeen) begin
      $display("[TB] FAIL post_counters: got cnt=%0d pre=%0d seen=%b want cnt=%0d pre=%0d seen=%b",
               sample_count_o, pretrig_count_o, trig_seen_o, mCount, mPre, mTrigSeen);
      nErr++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    nVec++;
    if (byte_ready_o !== 1'b1 || sample_valid_o !== 1'b0 || sample_count_o !== 32'd0 ||
        pretrig_count_o !== 32'd0 || trig_seen_o !== 1'b0 || done_o !== 1'b0 || sample_trig_o !== 1'b0) begin
      $display("[TB] FAIL reset_state: got br=%b sv=%b cnt=%0d pre=%0d seen=%b done=%b trig=%b",
               byte_ready_o, sample_valid_o, sample_count_o, pretrig_count_o, trig_seen_o, done_o, sample_trig_o);
      nErr++;
    end
    reset_i = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_single_word();
    send_word(32'h0040_1001);
    drain_word(32'h0040_1001, 100);
    nVec++;
    if (sample_count_o !== 32'd3 || pretrig_count_o !== 32'd0) begin
      $display("[TB] FAIL t1_counts: got cnt=%0d pre=%0d want cnt=3 pre=0", sample_count_o, pretrig_count_o);
      nErr++;
    end
  endtask

  task automatic test_trigger_order();
    logic [31:0] w;
    do_clear();
    w = 32'hC000_0000 | ($urandom() & 32'h3FFF_FFFF);
    send_word(w);
    drain_word(w, 100);
    w = 32'h8000_0000 | ($urandom() & 32'h3FFF_FFFF);
    send_word(w);
    drain_word(w, 100);
    nVec++;
    if (pretrig_count_o !== 32'd5 || trig_seen_o !== 1'b1) begin
      $display("[TB] FAIL t2_pretrig: got pre=%0d seen=%b want pre=5 seen=1", pretrig_count_o, trig_seen_o);
      nErr++;
    end
    w = 32'h8000_0000 | ($urandom() & 32'h3FFF_FFFF);
    send_word(w);
    drain_word(w, 100);
  endtask

  task automatic test_limit();
    logic [31:0] w;
    mMax          = 32'd4;
    max_samples_i = mMax;
    do_clear();
    for (int k = 0; k < 2; k++) begin
      w = $urandom();
      send_word(w);
      drain_word(w, 100);
    end
    // third word offered while DONE: nothing must be accepted or emitted
    for (int k = 0; k < 8; k++) begin
      byte_i       = 8'($urandom());
      byte_valid_i = 1'b1;
      sample_ready_i = 1'b1;
      @(negedge clk);
      nVec++;
      if (byte_ready_o !== 1'b0 || sample_valid_o !== 1'b0 || done_o !== 1'b1 || sample_count_o !== 32'd4) begin
        $display("[TB] FAIL t3_done_hold: got br=%b sv=%b done=%b cnt=%0d want br=0 sv=0 done=1 cnt=4",
                 byte_ready_o, sample_valid_o, done_o, sample_count_o);
        nErr++;
      end
    end
    byte_valid_i   = 1'b0;
    sample_ready_i = 1'b0;
    mMax           = 32'd0;
    max_samples_i  = mMax;
    do_clear();
  endtask

  task automatic test_stall();
    logic [31:0] w;
    do_clear();
    for (int k = 0; k < 100; k++) begin
      w = $urandom();
      send_word(w);
      drain_word(w, 50);
    end
    nVec++;
    if (sample_count_o !== 32'd300) begin
      $display("[TB] FAIL t4_total: got %0d want 300", sample_count_o);
      nErr++;
    end
  endtask

  task automatic test_reset_midword();
    logic [31:0] w;
    do_clear();
    w = $urandom();
    send_word(w);
    drain_word(w, 100);
    // two bytes of a partial word, then async reset between edges
    for (int b = 0; b < 2; b++) begin
      byte_i       = 8'($urandom());
      byte_valid_i = 1'b1;
      @(negedge clk);
    end
    byte_valid_i = 1'b0;
    #2;
    reset_i = 1'b1;
    #1;
    nVec++;
    if (byte_ready_o !== 1'b1 || sample_valid_o !== 1'b0 || sample_count_o !== 32'd0 ||
        pretrig_count_o !== 32'd0 || trig_seen_o !== 1'b0 || done_o !== 1'b0) begin
      $display("[TB] FAIL t5_async_reset: got br=%b sv=%b cnt=%0d pre=%0d seen=%b done=%b",
               byte_ready_o, sample_valid_o, sample_count_o, pretrig_count_o, trig_seen_o, done_o);
      nErr++;
    end
    @(negedge clk);
    reset_i = 1'b0;
    model_reset();
    @(negedge clk);
    w = $urandom();
    send_word(w);
    drain_word(w, 100);
  endtask

  task automatic test_clear_on_trigger();
    logic [31:0] w;
    do_clear();
    w = 32'h4000_0000 | ($urandom() & 32'h3FFF_FFFF);
    send_word(w);
    nVec++;
    if (sample_valid_o !== 1'b1 || sample_trig_o !== 1'b0 || sample_o !== w[9:0]) begin
      $display("[TB] FAIL t6_idx0: got sv=%b trig=%b s=%h want sv=1 trig=0 s=%h",
               sample_valid_o, sample_trig_o, sample_o, w[9:0]);
      nErr++;
    end
    sample_ready_i = 1'b1;
    @(negedge clk);
    nVec++;
    if (sample_trig_o !== 1'b1 || sample_o !== w[19:10]) begin
      $display("[TB] FAIL t6_idx1: got trig=%b s=%h want trig=1 s=%h", sample_trig_o, sample_o, w[19:10]);
      nErr++;
    end
    clear_i = 1'b1;
    @(negedge clk);
    clear_i        = 1'b0;
    sample_ready_i = 1'b0;
    model_reset();
    nVec++;
    if (trig_seen_o !== 1'b0 || sample_count_o !== 32'd0 || pretrig_count_o !== 32'd0 ||
        byte_ready_o !== 1'b1 || sample_valid_o !== 1'b0 || done_o !== 1'b0) begin
      $display("[TB] FAIL t6_clear: got seen=%b cnt=%0d pre=%0d br=%b sv=%b done=%b",
               trig_seen_o, sample_count_o, pretrig_count_o, byte_ready_o, sample_valid_o, done_o);
      nErr++;
    end
    w = $urandom();
    send_word(w);
    drain_word(w, 70);
  endtask

  initial begin
    reset_i        = 1'b1;
    clear_i        = 1'b0;
    mMax           = 32'd0;
    max_samples_i  = 32'd0;
    byte_i         = 8'd0;
    byte_valid_i   = 1'b0;
    sample_ready_i = 1'b0;
    model_reset();

    test_reset();
    test_single_word();
    test_trigger_order();
    test_limit();
    test_stall();
    test_reset_midword();
    test_clear_on_trigger();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
